// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/fetch bus between decode logic and the program-counter unit
interface pc_unit_if #(
    parameter int ADDR_W    = 5,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              stall;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_off;
    logic              jump_en;
    logic              call_en;
    logic              ret_en;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] next_addr;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_overflow;
    logic              ras_underflow;

    // decode/control side: issues requests, observes the fetch address
    modport master (
        output stall, branch_en, branch_off, jump_en, call_en, ret_en, jump_addr,
        input  addr, next_addr, ras_count, ras_overflow, ras_underflow
    );

    // program-counter side
    modport slave (
        input  stall, branch_en, branch_off, jump_en, call_en, ret_en, jump_addr,
        output addr, next_addr, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with branch/jump/call/return and circular return-address stack
module pc_unit #(
    parameter int ADDR_W     = 5,
    parameter int RESET_ADDR = 0,
    parameter int STEP       = 1,
    parameter int RAS_DEPTH  = 4
) (
    input logic     clk,
    input logic     rst_n,
    pc_unit_if.slave bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;
    // a single-entry stack still needs a 1-bit pointer; it simply never moves
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_ADDR);
    localparam logic [CNT_W-1:0]  FULL_V  = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;      // next free slot; top of stack sits one below
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_next;
    logic [PTR_W-1:0]  w_ptr_inc;
    logic [PTR_W-1:0]  w_ptr_dec;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_underflow;

    // modulo-2^ADDR_W arithmetic: the branch offset is already ADDR_W wide,
    // so a plain add is equivalent to adding its sign-extended value
    assign w_inc     = r_addr + STEP_V;
    assign w_ptr_inc = (RAS_DEPTH == 1) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_dec = (RAS_DEPTH == 1) ? '0 : r_ptr - PTR_W'(1);
    assign w_full    = (r_count == FULL_V);

    // next-address selection in priority order: stall, ret, call, jump, branch, step
    always_comb begin
        w_next      = w_inc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        if (bus.stall) begin
            w_next = r_addr;
        end else if (bus.ret_en) begin
            if (r_count != '0) begin
                w_next = r_ras[w_ptr_dec];
                w_pop  = 1'b1;
            end else begin
                w_underflow = 1'b1;
            end
        end else if (bus.call_en) begin
            w_next = bus.jump_addr;
            w_push = 1'b1;
        end else if (bus.jump_en) begin
            w_next = bus.jump_addr;
        end else if (bus.branch_en) begin
            w_next = r_addr + bus.branch_off;
        end
    end

    // PC, stack pointer/count and the one-cycle error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= RESET_V;
            r_ptr       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_addr      <= w_next;
            r_overflow  <= w_push && w_full;
            r_underflow <= w_underflow;
            if (w_push) begin
                r_ptr <= w_ptr_inc;
                if (!w_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_ptr   <= w_ptr_dec;
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // stack storage; when full the write slot is the oldest entry, so it is overwritten
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_ras[r_ptr] <= w_inc;
        end
    end

    assign bus.addr          = r_addr;
    assign bus.next_addr     = w_next;
    assign bus.ras_count     = r_count;
    assign bus.ras_overflow  = r_overflow;
    assign bus.ras_underflow = r_underflow;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit
module tb_pc_unit;
    localparam int ADDR_W    = 5;
    localparam int RAS_DEPTH = 4;

    // control code bits for step()
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_BR   = 5'b00001;
    localparam logic [4:0] C_JP   = 5'b00010;
    localparam logic [4:0] C_CL   = 5'b00100;
    localparam logic [4:0] C_RT   = 5'b01000;
    localparam logic [4:0] C_ST   = 5'b10000;

    typedef struct packed {
        logic [4:0] addr;
        logic [2:0] cnt;
        logic       ovf;
        logic       und;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    exp_t q[$];

    pc_unit_if #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_unit #(.ADDR_W(ADDR_W), .RESET_ADDR(0), .STEP(1), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle of requests, then queue the state expected after the edge
    task automatic step(input logic [4:0] ctl, input logic [4:0] off, input logic [4:0] ja,
                        input logic [4:0] ea, input logic [2:0] ec,
                        input logic eo, input logic eu);
        exp_t e;
        bus.stall      = ctl[4];
        bus.ret_en     = ctl[3];
        bus.call_en    = ctl[2];
        bus.jump_en    = ctl[1];
        bus.branch_en  = ctl[0];
        bus.branch_off = off;
        bus.jump_addr  = ja;
        @(posedge clk);
        #1;
        e.addr = ea;
        e.cnt  = ec;
        e.ovf  = eo;
        e.und  = eu;
        q.push_back(e);
    endtask

    // monitor: registered outputs are compared on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("addr", int'(bus.addr), int'(e.addr));
                chk("ras_count", int'(bus.ras_count), int'(e.cnt));
                chk("ras_overflow", int'(bus.ras_overflow), int'(e.ovf));
                chk("ras_underflow", int'(bus.ras_underflow), int'(e.und));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.stall = 0; bus.ret_en = 0; bus.call_en = 0; bus.jump_en = 0; bus.branch_en = 0;
        bus.branch_off = '0; bus.jump_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_addr", int'(bus.addr), 0);
        chk("reset_count", int'(bus.ras_count), 0);
        chk("reset_ovf", int'(bus.ras_overflow), 0);
        chk("reset_und", int'(bus.ras_underflow), 0);
        rst_n = 1'b1;

        // sequential increment with wrap: 1..31,0,1 then on to 10
        for (int i = 1; i <= 33; i++) step(C_NONE, 5'd0, 5'd0, 5'(i % 32), 3'd0, 1'b0, 1'b0);
        for (int i = 2; i <= 10; i++) step(C_NONE, 5'd0, 5'd0, 5'(i), 3'd0, 1'b0, 1'b0);

        // branch -3, jump, branch+jump (jump wins)
        step(C_BR,        5'b11101, 5'd0,  5'd7,  3'd0, 1'b0, 1'b0);
        step(C_JP,        5'd0,     5'd20, 5'd20, 3'd0, 1'b0, 1'b0);
        step(C_BR | C_JP, 5'd4,     5'd3,  5'd3,  3'd0, 1'b0, 1'b0);

        // stall outranks call
        step(C_NONE, 5'd0, 5'd0, 5'd4, 3'd0, 1'b0, 1'b0);
        step(C_NONE, 5'd0, 5'd0, 5'd5, 3'd0, 1'b0, 1'b0);
        step(C_NONE, 5'd0, 5'd0, 5'd6, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(C_ST | C_CL, 5'd0, 5'd15, 5'd6, 3'd0, 1'b0, 1'b0);
        step(C_CL, 5'd0, 5'd15, 5'd15, 3'd1, 1'b0, 1'b0);
        step(C_RT, 5'd0, 5'd0,  5'd7,  3'd0, 1'b0, 1'b0);

        // nested call/return from 2
        step(C_JP, 5'd0, 5'd2,  5'd2,  3'd0, 1'b0, 1'b0);
        step(C_CL, 5'd0, 5'd10, 5'd10, 3'd1, 1'b0, 1'b0);
        step(C_CL, 5'd0, 5'd20, 5'd20, 3'd2, 1'b0, 1'b0);
        step(C_RT, 5'd0, 5'd0,  5'd11, 3'd1, 1'b0, 1'b0);
        step(C_RT, 5'd0, 5'd0,  5'd3,  3'd0, 1'b0, 1'b0);

        // five calls from 3,8,12,16,24: fifth overflows, return address 4 is lost
        step(C_CL, 5'd0, 5'd8,  5'd8,  3'd1, 1'b0, 1'b0);
        step(C_CL, 5'd0, 5'd12, 5'd12, 3'd2, 1'b0, 1'b0);
        step(C_CL, 5'd0, 5'd16, 5'd16, 3'd3, 1'b0, 1'b0);
        step(C_CL, 5'd0, 5'd24, 5'd24, 3'd4, 1'b0, 1'b0);
        step(C_CL, 5'd0, 5'd30, 5'd30, 3'd4, 1'b1, 1'b0);
        step(C_RT, 5'd0, 5'd0,  5'd25, 3'd3, 1'b0, 1'b0);
        step(C_RT, 5'd0, 5'd0,  5'd17, 3'd2, 1'b0, 1'b0);
        step(C_RT, 5'd0, 5'd0,  5'd13, 3'd1, 1'b0, 1'b0);
        step(C_RT, 5'd0, 5'd0,  5'd9,  3'd0, 1'b0, 1'b0);

        // underflow at 9, pulse lasts one cycle
        step(C_RT,   5'd0, 5'd0, 5'd10, 3'd0, 1'b0, 1'b1);
        step(C_NONE, 5'd0, 5'd0, 5'd11, 3'd0, 1'b0, 1'b0);

        // 0 + (-1) wraps to 31, then 31 + 1 wraps to 0
        step(C_JP,   5'd0,     5'd0, 5'd0,  3'd0, 1'b0, 1'b0);
        step(C_BR,   5'b11111, 5'd0, 5'd31, 3'd0, 1'b0, 1'b0);
        step(C_NONE, 5'd0,     5'd0, 5'd0,  3'd0, 1'b0, 1'b0);

        // ret with call pops only
        step(C_CL,        5'd0, 5'd5,  5'd5, 3'd1, 1'b0, 1'b0);
        step(C_RT | C_CL, 5'd0, 5'd20, 5'd1, 3'd0, 1'b0, 1'b0);

        // two calls, then asynchronous reset mid-cycle
        step(C_CL, 5'd0, 5'd7, 5'd7, 3'd1, 1'b0, 1'b0);
        step(C_CL, 5'd0, 5'd9, 5'd9, 3'd2, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_addr", int'(bus.addr), 0);
        chk("async_reset_count", int'(bus.ras_count), 0);
        bus.call_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(C_NONE, 5'd0, 5'd0, 5'd1, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) chk("drain", q.size(), 0);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parameterised program-counter unit for the processor model, replacing the fixed 5-bit PC register. It holds the fetch address and selects the next address from sequential increment, PC-relative branch, absolute jump, call or return. A small internal return-address stack (RAS) supports call/return. It sits between the control/decode logic and instruction memory.

Parameters:
ADDR_W, 5, width of the program address in bits (min 2).
RESET_ADDR, 0, address loaded on reset.
STEP, 1, sequential increment per instruction.
RAS_DEPTH, 4, number of return-address stack entries (min 1, power of two).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC and RAS; all other requests ignored
branch_en  input  1  take PC-relative branch
branch_off  input  ADDR_W  signed two's-complement branch offset
jump_en  input  1  absolute jump
call_en  input  1  push return address, jump to jump_addr
ret_en  input  1  pop return address into PC
jump_addr  input  ADDR_W  target for jump_en / call_en
addr  output  ADDR_W  current fetch address (registered)
next_addr  output  ADDR_W  combinational address to be loaded on the next edge
ras_count  output  clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  output  1  registered one-cycle pulse: push while full
ras_underflow  output  1  registered one-cycle pulse: pop while empty

Behaviour:
- Reset (rst_n low, asynchronous): addr=RESET_ADDR, ras_count=0, ras_overflow=0, ras_underflow=0, RAS pointer=0. Reset mid-operation discards RAS contents and all pending requests.
- Single register stage: next_addr is computed combinationally from addr and the inputs. addr<=next_addr on every rising clk while rst_n is high.
- Next-address priority, highest first:
  1. stall: next_addr=addr; RAS unchanged; flags pulse 0.
  2. ret_en: if ras_count>0, next_addr=top entry, then pop. If empty, next_addr=addr+STEP and ras_underflow pulses 1.
  3. call_en: next_addr=jump_addr; push addr+STEP.
  4. jump_en: next_addr=jump_addr.
  5. branch_en: next_addr=addr+sign_extend(branch_off).
  6. Otherwise: next_addr=addr+STEP.
- A request at a given level masks all lower levels. Example: ret_en with call_en pops only and pushes nothing.
- All address arithmetic is modulo 2^ADDR_W. Wrap-around is silent: all-ones+1=0, and 0 plus an offset of -1 gives all-ones.
- RAS is a circular buffer with a top-of-stack pointer.
  - Push when ras_count<RAS_DEPTH: write, advance the pointer, increment the count.
  - Push when full: overwrite the oldest entry, advance the pointer, keep ras_count=RAS_DEPTH, pulse ras_overflow for one cycle.
  - Pop: retreat the pointer, decrement the count.
- ras_overflow and ras_underflow are registered. Each is high for exactly the cycle after the offending edge, then returns to 0 unless the condition repeats.
- Back-to-back calls or returns on consecutive cycles are fully supported with no bubble.
- No X propagation: RAS entries read when empty are never used.

Test Plan:
- Reset and increment: ADDR_W=5, RESET_ADDR=0. Assert rst_n low, release, run 33 cycles -> addr sequence 0,1,…,31,0,1 (wrap); flags stay 0.
- Branch and jump: at addr=10, branch_off=5'b11101 (-3) -> addr=7. Next, jump_en with jump_addr=20 -> addr=20. Next, branch_en and jump_en together with jump_addr=3 -> addr=3 (jump wins).
- Stall priority: at addr=6, assert stall with call_en, jump_addr=15 for 3 cycles -> addr holds 6 and ras_count stays 0. Release stall with call still held -> addr=15, ras_count=1.
- Call/return nesting: from addr=2, call to 10, then call to 20, then ret, then ret -> addr 10, 20, 11, 3; ras_count 1, 2, 1, 0.
- RAS overflow: RAS_DEPTH=4, five consecutive calls from addrs a0..a4 -> ras_overflow pulses one cycle after the fifth call, ras_count=4. Four returns yield a4+1, a3+1, a2+1, a1+1 (a0+1 lost).
- Underflow and async reset: ret_en with ras_count=0 at addr=9 -> addr=10 and ras_underflow=1 for one cycle. Drop rst_n mid-cycle after two calls -> addr=RESET_ADDR and ras_count=0 immediately, without waiting for a clock edge.
